// File: rtl/aes_spi_master.sv
// Host-side sequencer for the AES SPI slave: shifts plaintext then key out
// on SIMO, holds mode through the AES latency, then collects the ciphertext.
module aes_spi_master #(
  parameter int RESULT_WAIT = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] msg_in,
  input  logic [255:0] key_in,
  input  logic [1:0]   size_in,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [127:0] result,
  output logic         SIMO,
  output logic         CSS,
  output logic         mode,
  output logic [1:0]   size,
  input  logic         SOMI
);

  typedef enum logic [2:0] {
    IDLE, MSG, KEY, WAIT, READ, DONE
  } state_t;

  localparam logic [8:0] WLAST = 9'(RESULT_WAIT - 1);

  state_t       state_q;
  logic [8:0]   cnt_q;
  logic [127:0] msg_q;
  logic [255:0] key_q;
  logic [127:0] shadow_q;
  logic [127:0] result_q;
  logic [1:0]   size_q;
  logic         busy_q;
  logic         done_q;
  logic         err_q;
  logic         simo_q;
  logic         css_q;
  logic         mode_q;
  logic [8:0]   klast_d;

  // Key length always comes from the latched size, never the live input
  always_comb begin
    klast_d = 9'd127;
    unique case (1'b1)
      size_q == 2'b01: klast_d = 9'd191;
      size_q == 2'b10: klast_d = 9'd255;
      default:         klast_d = 9'd127;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      msg_q    <= '0;
      key_q    <= '0;
      shadow_q <= '0;
      result_q <= '0;
      size_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      simo_q   <= 1'b0;
      css_q    <= 1'b1;
      mode_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (size_in == 2'b11) begin
              err_q <= 1'b1;
            end else begin
              state_q <= MSG;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              css_q   <= 1'b0;
              size_q  <= size_in;
              simo_q  <= msg_in[0];
              msg_q   <= msg_in >> 1;
              key_q   <= key_in;
            end
          end
        end
        MSG: begin
          if (cnt_q == 9'd127) begin
            state_q <= KEY;
            cnt_q   <= '0;
            simo_q  <= key_q[0];
            key_q   <= key_q >> 1;
          end else begin
            cnt_q  <= cnt_q + 9'd1;
            simo_q <= msg_q[0];
            msg_q  <= msg_q >> 1;
          end
        end
        KEY: begin
          if (cnt_q == klast_d) begin
            state_q <= WAIT;
            cnt_q   <= '0;
            simo_q  <= 1'b0;
            mode_q  <= 1'b1;
          end else begin
            cnt_q  <= cnt_q + 9'd1;
            simo_q <= key_q[0];
            key_q  <= key_q >> 1;
          end
        end
        WAIT: begin
          if (cnt_q == WLAST) begin
            state_q <= READ;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 9'd1;
          end
        end
        READ: begin
          // First sample ends up in bit 0 after 128 right shifts
          shadow_q <= {SOMI, shadow_q[127:1]};
          if (cnt_q == 9'd127) begin
            state_q  <= DONE;
            cnt_q    <= '0;
            result_q <= {SOMI, shadow_q[127:1]};
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            css_q    <= 1'b1;
            mode_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 9'd1;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign result = result_q;
  assign SIMO   = simo_q;
  assign CSS    = css_q;
  assign mode   = mode_q;
  assign size   = size_q;

endmodule

// File: tb/tb_aes_spi_master.sv
// Bench for aes_spi_master: behavioural slave that captures SIMO and
// returns known AES ciphertexts for the captured (msg, key) pair.
module tb_aes_spi_master;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [127:0] msg_in;
  logic [255:0] key_in;
  logic [1:0]   size_in;
  logic         busy, done, err;
  logic [127:0] result;
  logic         SIMO, CSS, mode;
  logic [1:0]   size;
  logic         SOMI;

  always #5 clk = ~clk;

  aes_spi_master #(.RESULT_WAIT(W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .msg_in(msg_in), .key_in(key_in), .size_in(size_in),
    .busy(busy), .done(done), .err(err), .result(result),
    .SIMO(SIMO), .CSS(CSS), .mode(mode), .size(size),
    .SOMI(SOMI)
  );

  typedef struct {
    logic [1:0]   sz;
    logic [127:0] msg;
    logic [255:0] key;
    int           k;
    logic [127:0] ct;
    int           inject;
  } vec_t;

  vec_t tv[4];

  int ncmp = 0;
  int nfail = 0;

  task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] kmask(int n);
    logic [255:0] one;
    one = 256'd1;
    if (n >= 256) return '1;
    return (one << n) - one;
  endfunction

  // Behavioural slave
  logic [127:0] cap_msg;
  logic [255:0] cap_key;
  int           nbits;
  int           mcnt;
  logic [127:0] slave_ct;

  always @(posedge clk) begin
    if (CSS) begin
      nbits   <= 0;
      mcnt    <= 0;
      cap_msg <= '0;
      cap_key <= '0;
    end else if (!mode) begin
      if (nbits < 128) cap_msg[nbits] <= SIMO;
      else if (nbits < 384) cap_key[nbits-128] <= SIMO;
      nbits <= nbits + 1;
    end else begin
      mcnt <= mcnt + 1;
    end
  end

  always_comb begin
    slave_ct = 128'h0bad0bad0bad0bad0bad0bad0bad0bad;
    for (int i = 0; i < 3; i++)
      if (cap_msg == tv[i].msg && nbits == 128 + tv[i].k &&
          cap_key == (tv[i].key & kmask(tv[i].k)))
        slave_ct = tv[i].ct;
  end

  always_comb begin
    SOMI = 1'b0;
    if (mcnt >= W && mcnt < W + 128) SOMI = slave_ct[mcnt-W];
  end

  task automatic run_txn(input vec_t v, input string tag);
    int lat;
    int css_low;
    int szbad;
    @(negedge clk);
    start   = 1'b1;
    size_in = v.sz;
    msg_in  = v.msg;
    key_in  = v.key;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " accept busy/CSS/SIMO"}, {busy, CSS, SIMO}, {1'b1, 1'b0, v.msg[0]});
    msg_in  = ~v.msg;
    key_in  = ~v.key;
    size_in = 2'b11;
    lat = 1;
    css_low = 1;
    szbad = 0;
    while (!done && lat < 3000) begin
      @(negedge clk);
      lat++;
      if (lat == v.inject) begin
        start   = 1'b1;
        size_in = 2'b01;
        msg_in  = 128'h0123456789abcdef0123456789abcdef;
      end
      if (lat == v.inject + 1) start = 1'b0;
      if (!CSS) css_low++;
      if (busy && size != v.sz) szbad++;
      if (err) szbad++;
    end
    chk({tag, " latency"}, lat, 1 + 128 + v.k + W + 128);
    chk({tag, " result"}, result, v.ct);
    chk({tag, " captured msg"}, cap_msg, v.msg);
    chk({tag, " captured key"}, cap_key, v.key & kmask(v.k));
    chk({tag, " key bits"}, nbits - 128, v.k);
    chk({tag, " CSS low cycles"}, css_low, 320 + v.k);
    chk({tag, " size stable/no err"}, szbad, 0);
    chk({tag, " done state"}, {busy, CSS, mode}, {1'b0, 1'b1, 1'b0});
    @(negedge clk);
    chk({tag, " done pulse"}, {done, busy, CSS}, {1'b0, 1'b0, 1'b1});
  endtask

  initial begin
    int bad;
    tv[0] = '{2'b00, 128'h3243f6a8885a308d313198a2e0370734,
              {128'hffffffffffffffffffffffffffffffff,
               128'h2b7e151628aed2a6abf7158809cf4f3c},
              128, 128'h3925841d02dc09fbdc118597196a0b32, -1};
    tv[1] = '{2'b01, 128'h00112233445566778899aabbccddeeff,
              {64'ha5a5a5a5a5a5a5a5,
               192'h000102030405060708090a0b0c0d0e0f1011121314151617},
              192, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, -1};
    tv[2] = '{2'b10, 128'h00112233445566778899aabbccddeeff,
              256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
              256, 128'h8ea2b7ca516745bfeafc49904b496089, -1};
    tv[3] = tv[0];
    tv[3].inject = 128 + 40;

    reset = 1'b0;
    start = 1'b0;
    msg_in = '0;
    key_in = '0;
    size_in = 2'b00;
    repeat (3) @(negedge clk);
    chk("reset outputs",
        {busy, done, err, SIMO, CSS, mode, size},
        {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00});
    chk("reset result", result, 128'd0);
    reset = 1'b1;

    for (int i = 0; i < 4; i++) run_txn(tv[i], $sformatf("vec%0d", i));

    // Illegal key size
    @(negedge clk);
    start = 1'b1;
    size_in = 2'b11;
    msg_in = 128'hffffffffffffffffffffffffffffffff;
    @(negedge clk);
    start = 1'b0;
    chk("err pulse", {err, busy, CSS, done}, {1'b1, 1'b0, 1'b1, 1'b0});
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (err || busy || !CSS || SIMO || mode) bad++;
    end
    chk("err quiet after", bad, 0);
    chk("result held", result, tv[0].ct);

    // Reset during READ
    @(negedge clk);
    start = 1'b1;
    size_in = tv[1].sz;
    msg_in = tv[1].msg;
    key_in = tv[1].key;
    @(negedge clk);
    start = 1'b0;
    repeat (128 + 192 + W + 20) @(negedge clk);
    chk("in READ before abort", {mode, CSS, busy}, {1'b1, 1'b0, 1'b1});
    reset = 1'b0;
    #1;
    chk("abort async", {CSS, mode, busy, done}, {1'b1, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    reset = 1'b1;
    run_txn(tv[2], "after abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
